// File: rtl/pic_pkg.sv
// Shared constants for the programmable interrupt controller: port map, EOI code,
// line assignments and a lowest-set-bit helper used for fixed priority.
package pic_pkg;

   localparam int unsigned NUM_LINES = 8;

   localparam logic [15:0] PORT_PIC_CMD  = 16'h0020;
   localparam logic [15:0] PORT_PIC_DATA = 16'h0021;
   localparam logic [15:0] PORT_TMR_DATA = 16'h0040;
   localparam logic [15:0] PORT_TMR_CTL  = 16'h0043;

   localparam logic [7:0] EOI_CODE = 8'h20;

   localparam int unsigned LINE_TIMER    = 0;
   localparam int unsigned LINE_KBD      = 1;
   localparam int unsigned LINE_VRETRACE = 2;

   // Index of the lowest set bit (line 0 = highest priority); 0 when v is 0.
   function automatic logic [2:0] lowest_set(input logic [NUM_LINES-1:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = NUM_LINES - 1; i >= 0; i--) begin
         if (v[i]) r = 3'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/pic_timer.sv
// Interval timer feeding interrupt line 0: prescaler, 16-bit down-counter with
// reload, and low/high byte pointer for reload writes.
module pic_timer #(
   parameter int unsigned PRESCALE = 20
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_data_we,
   input  logic        i_ctl_we,
   input  logic [7:0]  i_wdata,
   output logic [15:0] o_count,
   output logic        o_pulse
);

   localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PS_W-1:0] r_presc;
   logic [15:0]     r_count;
   logic [15:0]     r_reload;
   logic [7:0]      r_lo;
   logic            r_ptr_hi;
   logic            r_pulse;
   logic            w_tick;

   assign w_tick  = (r_presc == PS_W'(PRESCALE - 1));
   assign o_count = r_count;
   assign o_pulse = r_pulse;

   // A reload of 0 counts 0 -> 0xFFFF -> ... -> 1, i.e. 65536 ticks.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_presc  <= '0;
         r_count  <= 16'hFFFF;
         r_reload <= 16'hFFFF;
         r_lo     <= 8'h00;
         r_ptr_hi <= 1'b0;
         r_pulse  <= 1'b0;
      end else begin
         r_pulse <= 1'b0;
         if (i_data_we && r_ptr_hi) begin
            r_reload <= {i_wdata, r_lo};
            r_count  <= {i_wdata, r_lo};
            r_presc  <= '0;
            r_ptr_hi <= 1'b0;
         end else begin
            if (i_data_we) begin
               r_lo     <= i_wdata;
               r_ptr_hi <= 1'b1;
            end
            if (i_ctl_we) r_ptr_hi <= 1'b0;
            r_presc <= w_tick ? '0 : r_presc + PS_W'(1);
            if (w_tick) begin
               if (r_count == 16'd1) begin
                  r_count <= r_reload;
                  r_pulse <= 1'b1;
               end else begin
                  r_count <= r_count - 16'd1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/pic_ctl.sv
// Programmable interrupt controller: IRR/IMR/ISR, fixed priority with nesting,
// holdoff between dispatches, toggle-style irq. Build option PIC_TIMER_EN adds the line-0 timer.
module pic_ctl
   import pic_pkg::*;
#(
   parameter int unsigned VECTOR_BASE = 8,
   parameter int unsigned HOLDOFF     = 16,
   parameter int unsigned PRESCALE    = 20
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  irq_req,
   input  logic [15:0] port_a,
   input  logic        port_w,
   input  logic        port_r,
   input  logic [7:0]  port_o,
   output logic [7:0]  port_i,
   output logic        port_hit,
   output logic        irq,
   output logic [7:0]  irq_in
);

   localparam int unsigned HO_W = (HOLDOFF > 2) ? $clog2(HOLDOFF) : 1;

   if (HOLDOFF < 1 || PRESCALE < 1) begin : g_bad_param
      $error("pic_ctl: HOLDOFF and PRESCALE must be at least 1");
   end

   logic [7:0]      r_irr, r_imr, r_isr, r_irq_in, r_port_i;
   logic            r_irq, r_port_hit;
   logic [HO_W-1:0] r_holdoff;

   logic [7:0] w_req, w_pend, w_disp_mask, w_eoi_mask, w_rd_data;
   logic [2:0] w_n, w_m;
   logic       w_dispatch, w_eoi, w_wr_imr, w_rd_hit;

`ifdef PIC_TIMER_EN
   logic [15:0] w_tmr_count;
   logic        w_tmr_pulse;

   pic_timer #(.PRESCALE(PRESCALE)) u_timer (
      .clock     (clock),
      .reset     (reset),
      .i_data_we (port_w && (port_a == PORT_TMR_DATA)),
      .i_ctl_we  (port_w && (port_a == PORT_TMR_CTL)),
      .i_wdata   (port_o),
      .o_count   (w_tmr_count),
      .o_pulse   (w_tmr_pulse)
   );

   always_comb begin
      w_req             = irq_req;
      w_req[LINE_TIMER] = w_tmr_pulse;
   end
`else
   assign w_req = irq_req;
`endif

   // Priority: the lowest pending unmasked line must beat the lowest in-service line.
   assign w_pend      = r_irr & ~r_imr;
   assign w_n         = lowest_set(w_pend);
   assign w_m         = lowest_set(r_isr);
   assign w_dispatch  = (w_pend != 8'h00) && ((r_isr == 8'h00) || (w_n < w_m))
                        && (r_holdoff == '0);
   assign w_disp_mask = w_dispatch ? (8'h01 << w_n) : 8'h00;

   assign w_eoi       = port_w && (port_a == PORT_PIC_CMD) && (port_o == EOI_CODE);
   assign w_eoi_mask  = (w_eoi && (r_isr != 8'h00)) ? (8'h01 << w_m) : 8'h00;
   assign w_wr_imr    = port_w && (port_a == PORT_PIC_DATA);

   always_comb begin
      w_rd_hit  = 1'b0;
      w_rd_data = r_port_i;
      if (port_r) begin
         case (port_a)
            PORT_PIC_CMD: begin
               w_rd_hit  = 1'b1;
               w_rd_data = r_irr;
            end
            PORT_PIC_DATA: begin
               w_rd_hit  = 1'b1;
               w_rd_data = r_imr;
            end
`ifdef PIC_TIMER_EN
            PORT_TMR_DATA: begin
               w_rd_hit  = 1'b1;
               w_rd_data = w_tmr_count[7:0];
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_irr      <= 8'h00;
         r_imr      <= 8'h00;
         r_isr      <= 8'h00;
         r_irq      <= 1'b0;
         r_irq_in   <= 8'(VECTOR_BASE);
         r_holdoff  <= '0;
         r_port_i   <= 8'h00;
         r_port_hit <= 1'b0;
      end else begin
         // New requests win over a same-cycle dispatch clear.
         r_irr      <= (r_irr & ~w_disp_mask) | w_req;
         r_isr      <= (r_isr & ~w_eoi_mask) | w_disp_mask;
         if (w_wr_imr) r_imr <= port_o;
         if (w_dispatch) begin
            r_irq     <= ~r_irq;
            r_irq_in  <= 8'(VECTOR_BASE + 32'(w_n));
            r_holdoff <= HO_W'(HOLDOFF - 1);
         end else if (r_holdoff != '0) begin
            r_holdoff <= r_holdoff - HO_W'(1);
         end
         r_port_i   <= w_rd_data;
         r_port_hit <= w_rd_hit;
      end
   end

   assign irq      = r_irq;
   assign irq_in   = r_irq_in;
   assign port_i   = r_port_i;
   assign port_hit = r_port_hit;

endmodule

// File: tb/tb_pic_ctl.sv
// Scoreboard bench for pic_ctl: stimulus pushes expected vectors (with edge windows)
// and read data; a negedge monitor pops and compares on every irq toggle / port_hit.
module tb_pic_ctl;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  irq_req;
   logic [15:0] port_a;
   logic        port_w, port_r;
   logic [7:0]  port_o;
   logic [7:0]  port_i;
   logic        port_hit;
   logic        irq;
   logic [7:0]  irq_in;

   pic_ctl dut (
      .clock    (clock),
      .reset    (reset),
      .irq_req  (irq_req),
      .port_a   (port_a),
      .port_w   (port_w),
      .port_r   (port_r),
      .port_o   (port_o),
      .port_i   (port_i),
      .port_hit (port_hit),
      .irq      (irq),
      .irq_in   (irq_in)
   );

   always #20 clock = ~clock;

   int unsigned cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

`ifdef PIC_TIMER_EN
   localparam logic [7:0] HI_MASK = 8'h02;
   localparam logic [7:0] HI_VEC  = 8'h09;
`else
   localparam logic [7:0] HI_MASK = 8'h01;
   localparam logic [7:0] HI_VEC  = 8'h08;
`endif

   typedef struct {
      logic [7:0]  vec;
      int unsigned lo;
      int unsigned hi;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] rd_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         rst_req  = 0;
   int         rst_ack  = 0;
   bit         done     = 1'b0;
   logic       prev_irq;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: sole owner of the counters.
   always @(negedge clock) begin
      exp_t e;
      logic [7:0] r;
      if (reset === 1'b1) begin
         if (rst_req != rst_ack) begin
            check("reset_irq", 16'(irq), 16'h0);
            check("reset_irq_in", 16'(irq_in), 16'h08);
            check("reset_port_hit", 16'(port_hit), 16'h0);
            check("reset_port_i", 16'(port_i), 16'h00);
            rst_ack = rst_req;
         end
         prev_irq = irq;
      end else begin
         if (irq !== prev_irq) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_irq: vector 0x%0h at edge %0d, none expected", irq_in, cyc);
            end else begin
               e = exp_q.pop_front();
               check("irq_vector", 16'(irq_in), 16'(e.vec));
               n_checks++;
               if (cyc < e.lo || cyc > e.hi) begin
                  n_fail++;
                  $display("FAIL irq_timing: vector 0x%0h at edge %0d, expected edge %0d..%0d",
                           irq_in, cyc, e.lo, e.hi);
               end
            end
         end
         prev_irq = irq;
         if (port_hit === 1'b1) begin
            if (rd_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_port_hit: data 0x%0h at edge %0d", port_i, cyc);
            end else begin
               r = rd_q.pop_front();
               check("read_data", 16'(port_i), 16'(r));
            end
         end
         if (done) begin
            while (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               n_checks++;
               n_fail++;
               $display("FAIL missing_irq: vector 0x%0h never seen, expected edge %0d..%0d",
                        e.vec, e.lo, e.hi);
            end
            while (rd_q.size() != 0) begin
               r = rd_q.pop_front();
               n_checks++;
               n_fail++;
               $display("FAIL missing_read: data 0x%0h never returned", r);
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic pulse(input logic [7:0] m);
      irq_req = m;
      tick();
      irq_req = 8'h00;
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      port_a = a;
      port_o = d;
      port_w = 1'b1;
      tick();
      port_w = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, input logic [7:0] e, input bit hit);
      if (hit) rd_q.push_back(e);
      port_a = a;
      port_r = 1'b1;
      tick();
      port_r = 1'b0;
   endtask

   task automatic expect_irq(input logic [7:0] v, input int unsigned at);
      exp_t e;
      e.vec = v;
      e.lo  = at;
      e.hi  = at;
      exp_q.push_back(e);
   endtask

   initial begin
      int unsigned k;
      reset   = 1'b1;
      irq_req = 8'h00;
      port_a  = 16'h0000;
      port_w  = 1'b0;
      port_r  = 1'b0;
      port_o  = 8'h00;
      idle(3);
      rst_req++;
      idle(1);
      reset = 1'b0;
      rd(16'h0020, 8'h00, 1'b1);
      rd(16'h0021, 8'h00, 1'b1);

      // Single request on keyboard line, then EOI.
      idle(2);
      k = cyc;
      expect_irq(8'h09, k + 2);
      pulse(8'h02);
      idle(20);
      rd(16'h0020, 8'h00, 1'b1);
      wr(16'h0020, 8'h20);
      idle(3);

      // Masked line latches but does not dispatch until unmasked.
      wr(16'h0021, 8'h02);
      pulse(8'h02);
      idle(20);
      rd(16'h0020, 8'h02, 1'b1);
      rd(16'h0021, 8'h02, 1'b1);
      k = cyc;
      expect_irq(8'h09, k + 2);
      wr(16'h0021, 8'h00);
      idle(20);
      wr(16'h0020, 8'h20);
      idle(3);

      // Nesting: higher line preempts after holdoff; lower line waits for both EOIs.
      k = cyc;
      expect_irq(8'h0A, k + 2);
      pulse(8'h04);
      idle(2);
      expect_irq(HI_VEC, k + 18);
      pulse(HI_MASK);
      idle(20);
      pulse(8'h08);
      idle(20);
      rd(16'h0020, 8'h08, 1'b1);
      wr(16'h0020, 8'h11);
      idle(20);
      wr(16'h0020, 8'h20);
      idle(20);
      k = cyc;
      expect_irq(8'h0B, k + 2);
      wr(16'h0020, 8'h20);
      idle(5);
      wr(16'h0020, 8'h20);
      idle(20);

      // Simultaneous requests: line 1 first, line 2 after EOI and full holdoff.
      k = cyc;
      expect_irq(8'h09, k + 2);
      expect_irq(8'h0A, k + 18);
      pulse(8'h06);
      tick();
      wr(16'h0020, 8'h20);
      idle(25);
      wr(16'h0020, 8'h20);
      idle(5);

      // EOI and dispatch in the same cycle both take effect.
      k = cyc;
      expect_irq(8'h0A, k + 2);
      pulse(8'h04);
      expect_irq(8'h09, k + 18);
      pulse(8'h02);
      idle(15);
      wr(16'h0020, 8'h20);
      idle(20);
      wr(16'h0020, 8'h20);
      k = cyc;
      expect_irq(8'h0B, k + 2);
      pulse(8'h08);
      idle(20);
      wr(16'h0020, 8'h20);
      idle(3);

      // Unmapped reads return no hit.
      rd(16'h0030, 8'h00, 1'b0);
`ifndef PIC_TIMER_EN
      rd(16'h0040, 8'h00, 1'b0);
`endif
      idle(3);

      // Reset with ISR and IRR populated discards everything.
      wr(16'h0021, 8'h80);
      k = cyc;
      expect_irq(8'h0A, k + 2);
      pulse(8'h04);
      idle(2);
      pulse(HI_MASK);
      idle(2);
      reset = 1'b1;
      tick();
      rst_req++;
      idle(2);
      reset = 1'b0;
      rd(16'h0020, 8'h00, 1'b1);
      rd(16'h0021, 8'h00, 1'b1);
      k = cyc;
      expect_irq(8'h0B, k + 2);
      pulse(8'h08);
      idle(20);
      wr(16'h0020, 8'h20);
      idle(3);

`ifdef PIC_TIMER_EN
      // Timer reload 3: line-0 dispatch every 60 clocks.
      wr(16'h0040, 8'h55);
      wr(16'h0043, 8'h00);
      wr(16'h0040, 8'h03);
      k = cyc;
      expect_irq(8'h08, k + 63);
      expect_irq(8'h08, k + 123);
      wr(16'h0040, 8'h00);
      rd(16'h0040, 8'h03, 1'b1);
      idle(65);
      wr(16'h0020, 8'h20);
      idle(60);
      wr(16'h0020, 8'h20);
      idle(3);
`endif

      idle(5);
      done = 1'b1;
   end

endmodule

// File: doc/pic_ctl.md
# pic_ctl

Programmable interrupt controller for the 16-bit board top: latches peripheral interrupt requests, applies a mask and fixed priority with nesting, and drives the core's toggle-style `irq` / `irq_in` pair. It replaces the ad-hoc pending-flag logic in the board top. Register access is over the CPU port bus at 0x20/0x21, and at 0x40 when the built-in timer is compiled in.

## Interface

Parameters:
- `VECTOR_BASE`, 8: vector emitted for line 0; line n emits `VECTOR_BASE + n`.
- `HOLDOFF`, 16: minimum clocks between two `irq` toggles.
- `PRESCALE`, 20: timer input divider; 25 MHz / 20 = 1.25 MHz.

Ports:
- `clock` in 1: system clock (25 MHz).
- `reset` in 1: synchronous, active-high.
- `irq_req` in 8: one-cycle request pulses from peripherals; bit 0 is timer, 1 is keyboard, 2 is vretrace.
- `port_a` in 16: CPU port address.
- `port_w` in 1: port write strobe, one cycle.
- `port_r` in 1: port read strobe, one cycle.
- `port_o` in 8: CPU write data.
- `port_i` out 8: read data, registered.
- `port_hit` out 1: high one cycle when `port_i` carries this block's data.
- `irq` out 1: toggles once per dispatched interrupt.
- `irq_in` out 8: vector, valid when `irq` toggles.

## Operation

- **IRR (request register):**
  - An `irq_req[n]` pulse sets `IRR[n]`.
  - Masked lines still latch into IRR.
  - If a set and a dispatch-clear hit the same bit in the same cycle, the set wins.
- **IMR (mask register):**
  - Written by a port 0x21 write; bit = 1 masks the line.
  - Reset value 0x00.
- **ISR (in-service register):**
  - The dispatched bit is set.
  - A port 0x20 write with `port_o == 8'h20` is a non-specific EOI: it clears the lowest-numbered set ISR bit.
  - Other values written to 0x20 are ignored.
- **Dispatch condition:** `P = IRR & ~IMR` is nonzero, and all of the following hold:
  - Its lowest set bit n is lower than the lowest set ISR bit, or ISR is 0.
  - The holdoff counter is 0.
- **Dispatch action:**
  - Clear `IRR[n]` and set `ISR[n]`.
  - `irq_in <= VECTOR_BASE + n`.
  - `irq <= ~irq`.
  - Load the holdoff counter with `HOLDOFF - 1`.
- **Priority:** line 0 highest, line 7 lowest. A higher-priority line nests over an in-service lower line.
- **Reads:**
  - 0x20 returns IRR.
  - 0x21 returns IMR.
  - 0x40 (timer builds only) returns the current count bits [7:0].
  - Any other address: `port_hit` stays 0 and `port_i` holds its value.
- **Same-cycle EOI and dispatch:** both take effect. The dispatch decision uses the pre-EOI ISR value.

## Timing

- **Reset values:**
  - IRR, ISR and IMR = 0.
  - `irq` = 0, `irq_in` = `VECTOR_BASE`.
  - `port_i` = 0, `port_hit` = 0.
  - Holdoff counter = 0.
  - Timer: reload 0xFFFF, count 0xFFFF, prescaler 0, byte pointer low.
- **Request latency:** a pulse in cycle N makes IRR visible after edge N+1. The earliest `irq` toggle with valid `irq_in` is at edge N+2.
- **Writes:** IMR and EOI effects are visible from the edge after `port_w`.
- **Reads:** `port_i` and `port_hit` are valid one edge after `port_r`.
- **Holdoff:** two dispatches are separated by at least `HOLDOFF` clocks. Requests arriving during holdoff stay pending in IRR.
- **Reset mid-operation:** all pending and in-service state is discarded. `irq` returns to 0.

## Configuration

- **`PIC_TIMER_EN` defined:** a built-in timer drives line 0 and `irq_req[0]` is ignored.
  - Count path: the prescaler divides by `PRESCALE`, and the counter decrements once per prescaler wrap.
  - Expiry: when the counter is 1 at a tick, it reloads and pulses line 0 for one cycle.
  - Reload value 0 means 65536.
  - Reload writes: port 0x40 writes go low byte first, then high byte. The high-byte write loads the reload value and restarts the counter and prescaler.
  - Port 0x43 writes reset the byte pointer to low.
- **`PIC_TIMER_EN` undefined:** line 0 is `irq_req[0]`. Ports 0x40 and 0x43 are not decoded.

## Structure

- **Shared package `pic_pkg`:**
  - Port address constants: 0x20, 0x21, 0x40, 0x43.
  - EOI code 8'h20.
  - Line indices: timer 0, keyboard 1, vretrace 2.
- **Sub-module `pic_timer`:** prescaler, 16-bit down-counter and byte-pointer logic. It is instantiated only under `PIC_TIMER_EN`.
- **Top logic:** IRR, ISR and IMR registers, priority encoder, holdoff counter and port decode.

## Test plan

- **Single request:** pulse `irq_req[1]` at cycle 10 → `irq` toggles 0→1 at edge 12 and `irq_in` = 0x09. EOI (write 0x20 to port 0x20) → ISR = 0.
- **Masking:** write 0x21 = 0x02, then pulse line 1 → no toggle, and a read of 0x20 returns 0x02. Write 0x21 = 0x00 → dispatch with `irq_in` = 0x09.
- **Nesting:** line 2 is in service when line 0 is pulsed → dispatches 0x08 after holdoff expires. Line 3 pulsed while line 2 is in service → stays pending until both EOIs.
- **Simultaneous requests:** lines 2 and 1 pulsed in the same cycle → 0x09 first. 0x0A follows only after EOI, never earlier than 16 clocks.
- **Timer (`PIC_TIMER_EN`):** write 0x40 = 0x03 then 0x00 → line-0 pulse every 60 clocks, and `irq_in` = 0x08.
- **Reset mid-service:** assert `reset` with ISR = 0x04 and IRR = 0x01 → next cycle all registers are 0, `irq` = 0 and `irq_in` = 0x08.
